// File: rtl/cmult_share_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cmult_share_arb_pkg
//  Description : Shared types and default widths for the complex-multiplier
//                arbiter and the multiplier it fronts.
//  Revision    : 1.0  initial release
// ============================================================================
package cmult_share_arb_pkg;

   localparam int c_IN_W = 16;
   localparam int c_TW_W = 12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

   typedef logic req_id_t;

endpackage
`default_nettype wire

// File: rtl/cmult_share_arb_tag_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : cmult_tag_pipe
//  Description : {valid,id} shift register tracking beats inside the
//                multiplier; the tail is compared against mul_valid_out.
//  Revision    : 1.0  initial release
// ============================================================================
module cmult_tag_pipe
   import cmult_share_arb_pkg::*;
#(
   parameter int MUL_LAT = 4
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    i_load_valid,
   input  req_id_t i_load_id,
   input  logic    i_res_valid,
   output logic    o_tail_valid,
   output logic    o_hit,
   output req_id_t o_hit_id,
   output logic    o_mismatch
);

   logic [MUL_LAT-1:0] r_vld;
   logic [MUL_LAT-1:0] r_id;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld <= '0;
         r_id  <= '0;
      end else begin
         for (int i = MUL_LAT - 1; i > 0; i--) begin
            r_vld[i] <= r_vld[i-1];
            r_id[i]  <= r_id[i-1];
         end
         r_vld[0] <= i_load_valid;
         r_id[0]  <= i_load_id;
      end
   end

   assign o_tail_valid = r_vld[MUL_LAT-1];
   assign o_hit        = r_vld[MUL_LAT-1] & i_res_valid;
   assign o_hit_id     = req_id_t'(r_id[MUL_LAT-1]);
   assign o_mismatch   = r_vld[MUL_LAT-1] ^ i_res_valid;

endmodule
`default_nettype wire

// File: rtl/cmult_share_arb.sv
`default_nettype none
// ============================================================================
//  Module      : cmult_share_arb
//  Description : Burst-limited round-robin sharing of one pipelined complex
//                multiplier between two requesters, with result routing.
//  Revision    : 1.0  initial release
// ============================================================================
module cmult_share_arb
   import cmult_share_arb_pkg::*;
#(
   parameter int IN_W      = c_IN_W,
   parameter int TW_W      = c_TW_W,
   parameter int MUL_LAT   = 4,
   parameter int MAX_BURST = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [IN_W-1:0] req0_re,
   input  logic [IN_W-1:0] req0_im,
   input  logic [TW_W-1:0] req0_tw_re,
   input  logic [TW_W-1:0] req0_tw_im,
   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [IN_W-1:0] req1_re,
   input  logic [IN_W-1:0] req1_im,
   input  logic [TW_W-1:0] req1_tw_re,
   input  logic [TW_W-1:0] req1_tw_im,
   output logic            mul_valid_in,
   output logic [IN_W-1:0] mul_re,
   output logic [IN_W-1:0] mul_im,
   output logic [TW_W-1:0] mul_tw_re,
   output logic [TW_W-1:0] mul_tw_im,
   input  logic            mul_valid_out,
   input  logic [IN_W-1:0] mul_res_re,
   input  logic [IN_W-1:0] mul_res_im,
   output logic            rsp0_valid,
   output logic [IN_W-1:0] rsp0_re,
   output logic [IN_W-1:0] rsp0_im,
   output logic            rsp1_valid,
   output logic [IN_W-1:0] rsp1_re,
   output logic [IN_W-1:0] rsp1_im,
   output logic            busy,
   output logic            tag_err
);

   localparam int c_BST_W = $clog2(MAX_BURST + 1);
   localparam int c_CNT_W = $clog2(MUL_LAT + 2);

   arb_state_t          r_state, w_state_nxt;
   logic                r_rr;
   logic [c_BST_W-1:0]  r_burst, w_burst_nxt, w_burst_inc;
   logic                w_burst_max;
   logic                w_grant0, w_grant1, w_accept;
   logic [c_CNT_W-1:0]  r_cnt;
   logic                r_mul_valid;
   req_id_t             r_mul_id;
   logic [IN_W-1:0]     r_mul_re, r_mul_im;
   logic [TW_W-1:0]     r_mul_tw_re, r_mul_tw_im;
   logic                r_rsp0_valid, r_rsp1_valid, r_tag_err;
   logic [IN_W-1:0]     r_rsp0_re, r_rsp0_im, r_rsp1_re, r_rsp1_im;
   logic                w_tail_valid, w_hit, w_mismatch;
   req_id_t             w_hit_id;

   assign w_burst_max = (r_burst == c_BST_W'(MAX_BURST));
   assign w_burst_inc = w_burst_max ? r_burst : r_burst + c_BST_W'(1);

   // Grant is purely combinational so a switch of owner costs no bubble.
   always_comb begin
      w_grant0    = 1'b0;
      w_grant1    = 1'b0;
      w_state_nxt = r_state;
      w_burst_nxt = r_burst;
      case (r_state)
         OWN0: begin
            if (req0_valid && !(w_burst_max && req1_valid)) w_grant0 = 1'b1;
            else if (req1_valid)                            w_grant1 = 1'b1;
         end
         OWN1: begin
            if (req1_valid && !(w_burst_max && req0_valid)) w_grant1 = 1'b1;
            else if (req0_valid)                            w_grant0 = 1'b1;
         end
         default: begin
            w_grant0 = req0_valid & (~req1_valid | ~r_rr);
            w_grant1 = req1_valid & (~req0_valid |  r_rr);
         end
      endcase
      if (w_grant0) begin
         w_state_nxt = OWN0;
         w_burst_nxt = (r_state == OWN0) ? w_burst_inc : c_BST_W'(1);
      end else if (w_grant1) begin
         w_state_nxt = OWN1;
         w_burst_nxt = (r_state == OWN1) ? w_burst_inc : c_BST_W'(1);
      end else begin
         w_state_nxt = IDLE;
      end
   end

   assign req0_ready = w_grant0;
   assign req1_ready = w_grant1;
   assign w_accept   = w_grant0 | w_grant1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_burst <= '0;
         r_rr    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_burst <= w_burst_nxt;
         if (w_accept) r_rr <= w_grant0;
      end
   end

   // Operand register; data holds when no beat is issued.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mul_valid <= 1'b0;
         r_mul_id    <= 1'b0;
         r_mul_re    <= '0;
         r_mul_im    <= '0;
         r_mul_tw_re <= '0;
         r_mul_tw_im <= '0;
      end else begin
         r_mul_valid <= w_accept;
         if (w_grant0) begin
            r_mul_id    <= 1'b0;
            r_mul_re    <= req0_re;
            r_mul_im    <= req0_im;
            r_mul_tw_re <= req0_tw_re;
            r_mul_tw_im <= req0_tw_im;
         end else if (w_grant1) begin
            r_mul_id    <= 1'b1;
            r_mul_re    <= req1_re;
            r_mul_im    <= req1_im;
            r_mul_tw_re <= req1_tw_re;
            r_mul_tw_im <= req1_tw_im;
         end
      end
   end

   cmult_tag_pipe #(
      .MUL_LAT (MUL_LAT)
   ) u_tag_pipe (
      .clk          (clk),
      .rst          (rst),
      .i_load_valid (r_mul_valid),
      .i_load_id    (r_mul_id),
      .i_res_valid  (mul_valid_out),
      .o_tail_valid (w_tail_valid),
      .o_hit        (w_hit),
      .o_hit_id     (w_hit_id),
      .o_mismatch   (w_mismatch)
   );

   // A beat leaves the in-flight count when its tag reaches the tail.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_accept && !w_tail_valid) begin
         r_cnt <= r_cnt + c_CNT_W'(1);
      end else if (!w_accept && w_tail_valid && r_cnt != '0) begin
         r_cnt <= r_cnt - c_CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rsp0_valid <= 1'b0;
         r_rsp1_valid <= 1'b0;
         r_rsp0_re    <= '0;
         r_rsp0_im    <= '0;
         r_rsp1_re    <= '0;
         r_rsp1_im    <= '0;
         r_tag_err    <= 1'b0;
      end else begin
         r_rsp0_valid <= w_hit & (w_hit_id == 1'b0);
         r_rsp1_valid <= w_hit & (w_hit_id == 1'b1);
         if (w_hit && w_hit_id == 1'b0) begin
            r_rsp0_re <= mul_res_re;
            r_rsp0_im <= mul_res_im;
         end
         if (w_hit && w_hit_id == 1'b1) begin
            r_rsp1_re <= mul_res_re;
            r_rsp1_im <= mul_res_im;
         end
         if (w_mismatch) r_tag_err <= 1'b1;
      end
   end

   assign mul_valid_in = r_mul_valid;
   assign mul_re       = r_mul_re;
   assign mul_im       = r_mul_im;
   assign mul_tw_re    = r_mul_tw_re;
   assign mul_tw_im    = r_mul_tw_im;
   assign rsp0_valid   = r_rsp0_valid;
   assign rsp0_re      = r_rsp0_re;
   assign rsp0_im      = r_rsp0_im;
   assign rsp1_valid   = r_rsp1_valid;
   assign rsp1_re      = r_rsp1_re;
   assign rsp1_im      = r_rsp1_im;
   assign busy         = (r_cnt != '0);
   assign tag_err      = r_tag_err;

endmodule
`default_nettype wire
